// File: rtl/pll_devkit_pkg.sv
// Shared types and widths for the devkit PLL supervision logic.
// Holds the supervisor state encoding and counter sizing helpers.
package pll_devkit_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   localparam int unsigned RETRY_W = 4;
   localparam int unsigned LOSS_W  = 8;

   localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

   // Bits needed to hold 0..max-1 of the largest of three cycle counts.
   function automatic int unsigned cnt_width(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Two back-to-back capture stages to settle metastability.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier running on the reference clock.
// Retries on lock timeout and gates the downstream system reset.
module pll_lock_supervisor
   import pll_devkit_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 7
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               locked,
   output logic               pll_rst,
   output logic               sys_reset,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_count,
   output logic [LOSS_W-1:0]  lock_loss_count
);

   localparam int unsigned CNT_W = cnt_width(
      RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

   localparam logic [CNT_W-1:0] C_RST_LAST =
      CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST =
      CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STB_LAST =
      CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] C_MAX_RETRY =
      RETRY_W'(MAX_RETRIES);

   logic               w_lock_s;
   state_t             r_state;
   state_t             w_nxt_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [RETRY_W-1:0] r_retry;
   logic [RETRY_W-1:0] w_nxt_retry;
   logic [LOSS_W-1:0]  r_loss;
   logic [LOSS_W-1:0]  w_nxt_loss;
   logic               r_pll_rst;
   logic               r_sys_reset;
   logic               r_ready;
   logic               r_fail;
   logic               w_nxt_pll_rst;
   logic               w_nxt_sys_reset;
   logic               w_nxt_ready;
   logic               w_nxt_fail;

   sync_2ff #(
      .W (1)
   ) u_lock_sync (
      .i_clk (refclk),
      .i_rst (rst),
      .i_d   (locked),
      .o_q   (w_lock_s)
   );

   // Next state, retry/loss bookkeeping and shared cycle counter.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_retry = r_retry;
      w_nxt_loss  = r_loss;
      w_nxt_cnt   = r_cnt;
      unique case (r_state)
         ST_PLL_RST: begin
            if (r_cnt == C_RST_LAST) w_nxt_state = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (w_lock_s) begin
               w_nxt_state = ST_STABLE;
            end else if (r_cnt == C_TO_LAST) begin
               if (r_retry == C_MAX_RETRY) begin
                  w_nxt_state = ST_FAIL;
               end else begin
                  w_nxt_retry = r_retry + 1'b1;
                  w_nxt_state = ST_PLL_RST;
               end
            end
         end
         ST_STABLE: begin
            if (!w_lock_s) w_nxt_state = ST_WAIT_LOCK;
            else if (r_cnt == C_STB_LAST) w_nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (!w_lock_s) begin
               w_nxt_state = ST_PLL_RST;
               if (r_loss != LOSS_MAX) w_nxt_loss = r_loss + 1'b1;
            end
         end
         ST_FAIL: begin
            w_nxt_state = ST_FAIL;
         end
         default: begin
            w_nxt_state = ST_PLL_RST;
         end
      endcase
      if (w_nxt_state == ST_RUN && r_state != ST_RUN) begin
         w_nxt_retry = '0;
      end
      // Timed states count up; the counter restarts on every change.
      if (w_nxt_state != r_state) begin
         w_nxt_cnt = '0;
      end else if (r_state == ST_PLL_RST || r_state == ST_WAIT_LOCK ||
                   r_state == ST_STABLE) begin
         w_nxt_cnt = r_cnt + 1'b1;
      end
   end

   // Moore outputs decoded from the upcoming state so they register with it.
   always_comb begin
      w_nxt_pll_rst   = (w_nxt_state == ST_PLL_RST);
      w_nxt_sys_reset = (w_nxt_state != ST_RUN);
      w_nxt_ready     = (w_nxt_state == ST_RUN);
      w_nxt_fail      = (w_nxt_state == ST_FAIL);
   end

   // State, counter and registered outputs.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_PLL_RST;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_loss      <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_reset <= 1'b1;
         r_ready     <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         r_retry     <= w_nxt_retry;
         r_loss      <= w_nxt_loss;
         r_pll_rst   <= w_nxt_pll_rst;
         r_sys_reset <= w_nxt_sys_reset;
         r_ready     <= w_nxt_ready;
         r_fail      <= w_nxt_fail;
      end
   end

   assign pll_rst         = r_pll_rst;
   assign sys_reset       = r_sys_reset;
   assign ready           = r_ready;
   assign fail            = r_fail;
   assign retry_count     = r_retry;
   assign lock_loss_count = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: an interval-scanning model
// predicts every output change; a monitor matches each DUT change.
module tb_pll_lock_supervisor;

   localparam int RSTP = 4;
   localparam int TO   = 20;
   localparam int STB  = 8;
   localparam int MAXR = 2;
   localparam int MAXN = 512;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic       fail;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   typedef struct {
      int         n;
      logic [15:0] v;
   } ev_t;

   ev_t  q[$];
   int   lk[MAXN];
   int   edge_n = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [15:0] prev_v = '0;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES    (RSTP),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (STB),
      .MAX_RETRIES         (MAXR)
   ) dut (
      .refclk          (clk),
      .rst             (rst),
      .locked          (locked),
      .pll_rst         (pll_rst),
      .sys_reset       (sys_reset),
      .ready           (ready),
      .fail            (fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   function automatic logic [15:0] pk(
      input logic p, input logic s, input logic r, input logic f,
      input int rc, input int lc);
      logic [3:0] rc4;
      logic [7:0] lc8;
      rc4 = rc[3:0];
      lc8 = lc[7:0];
      return {p, s, r, f, rc4, lc8};
   endfunction

   function automatic logic [15:0] outv();
      return {pll_rst, sys_reset, ready, fail, retry_count, lock_loss_count};
   endfunction

   // locked value sampled at edge n (edge 1 = first edge after release)
   function automatic int lkv(input int n);
      return (n >= 1 && n < MAXN) ? lk[n] : 0;
   endfunction

   // synchronized lock as seen by the controller at edge n
   function automatic int ls(input int n);
      return (n >= 3) ? lkv(n - 2) : 0;
   endfunction

   function automatic int find(input int a, input int b, input int v);
      for (int n = a; n <= b; n++) if (ls(n) == v) return n;
      return -1;
   endfunction

   function automatic void push(input int n, input logic [15:0] v,
                                input int stop);
      ev_t e;
      e.n = n;
      e.v = v;
      if (n <= stop) q.push_back(e);
   endfunction

   // Walk the locked waveform interval by interval and list output changes.
   task automatic model(input int stop);
      int t, e, s, m, rc, lc, oc;
      bit done;
      t = 0; rc = 0; lc = 0; done = 0;
      while (!done && t <= stop) begin
         t = t + RSTP;
         push(t, pk(0, 1, 0, 0, rc, lc), stop);
         e = t;
         oc = 0;
         while (oc == 0 && e <= stop) begin
            m = find(e + 1, e + TO, 1);
            if (m < 0) begin
               t = e + TO;
               if (rc == MAXR) begin
                  push(t, pk(0, 1, 0, 1, rc, lc), stop);
                  oc = 3;
               end else begin
                  rc++;
                  push(t, pk(1, 1, 0, 0, rc, lc), stop);
                  oc = 2;
               end
            end else begin
               s = m;
               m = find(s + 1, s + STB, 0);
               if (m < 0) begin
                  t = s + STB;
                  rc = 0;
                  push(t, pk(0, 0, 1, 0, rc, lc), stop);
                  oc = 1;
               end else begin
                  e = m;
               end
            end
         end
         if (oc == 0 || oc == 3) done = 1;
         if (oc == 1) begin
            m = find(t + 1, stop + 1, 0);
            t = (m < 0) ? stop + 1 : m;
            if (lc < 255) lc++;
            push(t, pk(1, 1, 0, 0, rc, lc), stop);
         end
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rst) edge_n <= 0;
      else edge_n <= edge_n + 1;
   end

   // Monitor: every change of the output bundle must match the queue head.
   always @(negedge clk) begin
      logic [15:0] cur;
      ev_t e;
      cur = outv();
      if (rst) begin
         prev_v = cur;
      end else if (cur !== prev_v) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: edge %0d got %h want none",
                     edge_n, cur);
         end else begin
            e = q.pop_front();
            if (e.n != edge_n || e.v !== cur) begin
               n_bad++;
               $display("FAIL event: got edge %0d val %h want edge %0d val %h",
                        edge_n, cur, e.n, e.v);
            end
         end
         prev_v = cur;
      end
   end

   task automatic run_scn(input int stop);
      rst = 1'b1;
      locked = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_hold", outv(), pk(1, 1, 0, 0, 0, 0));
      q.delete();
      model(stop);
      locked = lkv(1) != 0;
      rst = 1'b0;
      for (int n = 1; n <= stop; n++) begin
         @(negedge clk);
         locked = lkv(n + 1) != 0;
      end
      #2 rst = 1'b1;
      #1 chk("async_rst", outv(), pk(1, 1, 0, 0, 0, 0));
      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events: got %0d pending, first edge %0d val %h, want 0",
                  q.size(), q[0].n, q[0].v);
      end
   endtask

   task automatic set_step(input int from);
      for (int n = 0; n < MAXN; n++) lk[n] = (n >= from) ? 1 : 0;
   endtask

   task automatic set_zero(input int a, input int b);
      for (int n = a; n <= b; n++) lk[n] = 0;
   endtask

   task automatic set_rand();
      int n, len, val;
      n = 1;
      val = int'($urandom_range(0, 1));
      lk[0] = 0;
      while (n < MAXN) begin
         if (val != 0) len = int'($urandom_range(2, 40));
         else if ($urandom_range(0, 5) == 0) len = int'($urandom_range(20, 90));
         else len = int'($urandom_range(1, 12));
         for (int i = 0; i < len && n < MAXN; i++) begin
            lk[n] = val;
            n++;
         end
         val = 1 - val;
      end
   endtask

   initial begin
      int stop;
      // clean lock
      set_step(7);
      run_scn(40);
      // retry then fail
      set_step(MAXN);
      run_scn(90);
      // chatter while qualifying
      set_step(7);
      set_zero(12, 14);
      run_scn(45);
      // loss in RUN and relock
      set_step(7);
      set_zero(30, 33);
      run_scn(80);
      // lock on the timeout edge
      set_step(22);
      run_scn(45);
      // async reset while qualifying
      set_step(7);
      run_scn(12);
      // random waveforms
      for (int k = 0; k < 20; k++) begin
         set_rand();
         if ($urandom_range(0, 3) == 0) stop = int'($urandom_range(5, 60));
         else stop = int'($urandom_range(150, 450));
         run_scn(stop);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
